// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-write/three-read register file with busy scoreboard, PC alias, CPSR
// Optional: define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_sb #(
   parameter int                DATA_W   = 32,
   parameter int                NUM_REGS = 16,
   parameter int                ADDR_W   = 4,
   parameter logic [DATA_W-1:0] PC_RESET = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic [ADDR_W-1:0] rd_addr3,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] rd_data3,
   output logic              rd_busy1,
   output logic              rd_busy2,
   output logic              rd_busy3,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   input  logic              pc_wr,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              pc_inc,
   input  logic              cpsr_wr,
   input  logic [DATA_W-1:0] cpsr_in,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] cpsr,
   output logic              wr_conflict
);

   localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(NUM_REGS - 1);
   localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

   // The top address has no array entry: it is served by the PC register.
   logic [DATA_W-1:0]   regs [NUM_REGS-1];
   logic [NUM_REGS-2:0] busy;
   logic [DATA_W-1:0]   pc_q;
   logic [DATA_W-1:0]   pc_next;
   logic [DATA_W-1:0]   cpsr_q;
   logic                conflict_q;

   logic [ADDR_W-1:0]   ra   [3];
   logic [DATA_W-1:0]   rdat [3];
   logic                rbsy [3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (wr_en2 && wr_addr2 == ADDR_W'(i)) regs[i] <= wr_data2;
            else if (wr_en1 && wr_addr1 == ADDR_W'(i)) regs[i] <= wr_data1;
            // A claim landing with the write keeps the register pending.
            if (claim_en && claim_addr == ADDR_W'(i)) busy[i] <= 1'b1;
            else if ((wr_en2 && wr_addr2 == ADDR_W'(i)) ||
                     (wr_en1 && wr_addr1 == ADDR_W'(i))) busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      pc_next = pc_q;
      if (pc_wr) pc_next = pc_in;
      else if (wr_en2 && wr_addr2 == TOP) pc_next = wr_data2;
      else if (wr_en1 && wr_addr1 == TOP) pc_next = wr_data1;
      else if (pc_inc) pc_next = pc_q + STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_RESET;
         cpsr_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         pc_q       <= pc_next;
         if (cpsr_wr) cpsr_q <= cpsr_in;
         conflict_q <= wr_en1 && wr_en2 && (wr_addr1 == wr_addr2);
      end
   end

   assign ra[0] = rd_addr1;
   assign ra[1] = rd_addr2;
   assign ra[2] = rd_addr3;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rdat[p] = '0;
         rbsy[p] = 1'b0;
         if (ra[p] == TOP) begin
            rdat[p] = pc_q;
`ifdef REG_FILE_BYPASS_EN
            if (pc_wr) rdat[p] = pc_in;
            else if (wr_en2 && wr_addr2 == TOP) rdat[p] = wr_data2;
            else if (wr_en1 && wr_addr1 == TOP) rdat[p] = wr_data1;
`endif
         end else begin
            rdat[p] = regs[ra[p]];
            rbsy[p] = busy[ra[p]];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en2 && wr_addr2 == ra[p]) begin
               rdat[p] = wr_data2;
               rbsy[p] = claim_en && (claim_addr == ra[p]);
            end else if (wr_en1 && wr_addr1 == ra[p]) begin
               rdat[p] = wr_data1;
               rbsy[p] = claim_en && (claim_addr == ra[p]);
            end
`endif
         end
      end
   end

   assign rd_data1    = rdat[0];
   assign rd_data2    = rdat[1];
   assign rd_data3    = rdat[2];
   assign rd_busy1    = rbsy[0];
   assign rd_busy2    = rbsy[1];
   assign rd_busy3    = rbsy[2];
   assign pc          = pc_q;
   assign cpsr        = cpsr_q;
   assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed vector table plus randomized model comparison for reg_file_sb
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rd_addr1, rd_addr2, rd_addr3;
   logic [31:0] rd_data1, rd_data2, rd_data3;
   logic        rd_busy1, rd_busy2, rd_busy3;
   logic        wr_en1, wr_en2, claim_en, pc_wr, pc_inc, cpsr_wr;
   logic [3:0]  wr_addr1, wr_addr2, claim_addr;
   logic [31:0] wr_data1, wr_data2, pc_in, cpsr_in;
   logic [31:0] pc, cpsr;
   logic        wr_conflict;

   int errors = 0;
   int checks = 0;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .rd_busy3(rd_busy3),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .pc_wr(pc_wr), .pc_in(pc_in), .pc_inc(pc_inc),
      .cpsr_wr(cpsr_wr), .cpsr_in(cpsr_in),
      .pc(pc), .cpsr(cpsr), .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        w1;  logic [3:0] a1; logic [31:0] d1;
      logic        w2;  logic [3:0] a2; logic [31:0] d2;
      logic        cl;  logic [3:0] ca;
      logic        pw;  logic [31:0] pi; logic inc;
      logic [3:0]  ra;
      logic [31:0] exp_data; logic exp_busy; logic [31:0] exp_pc; logic exp_conf;
   } vec_t;

   vec_t vecs [$];

   // Reference state, updated from the architectural rules.
   logic [31:0] m_mem [16];
   logic        m_busy [16];
   logic [31:0] m_pc, m_cpsr;
   logic        m_conf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0;
      wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0;
      claim_en = 0; claim_addr = 0;
      pc_wr = 0; pc_in = 0; pc_inc = 0;
      cpsr_wr = 0; cpsr_in = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
      m_pc = 0; m_cpsr = 0; m_conf = 0;
   endtask

   task automatic model_step();
      logic [31:0] npc;
      if (wr_en1 && wr_addr1 != 15) begin m_mem[wr_addr1] = wr_data1; m_busy[wr_addr1] = 0; end
      if (wr_en2 && wr_addr2 != 15) begin m_mem[wr_addr2] = wr_data2; m_busy[wr_addr2] = 0; end
      if (claim_en && claim_addr != 15) m_busy[claim_addr] = 1;
      npc = m_pc;
      if (pc_wr) npc = pc_in;
      else if (wr_en2 && wr_addr2 == 15) npc = wr_data2;
      else if (wr_en1 && wr_addr1 == 15) npc = wr_data1;
      else if (pc_inc) npc = m_pc + 32'd4;
      m_pc = npc;
      if (cpsr_wr) m_cpsr = cpsr_in;
      m_conf = wr_en1 && wr_en2 && (wr_addr1 == wr_addr2);
   endtask

   function automatic logic [31:0] m_rd(input logic [3:0] a);
      return (a == 15) ? m_pc : m_mem[a];
   endfunction

   function automatic logic m_rb(input logic [3:0] a);
      return (a == 15) ? 1'b0 : m_busy[a];
   endfunction

   initial begin
      idle_inputs();
      rd_addr1 = 0; rd_addr2 = 7; rd_addr3 = 14;
      rst_n = 0;
      #3;
      chk("rst_pc", pc, 0);
      chk("rst_cpsr", cpsr, 0);
      chk("rst_conf", {31'b0, wr_conflict}, 0);
      chk("rst_rd1", rd_data1, 0);
      chk("rst_rd2", rd_data2, 0);
      chk("rst_rd3", rd_data3, 0);
      chk("rst_busy", {29'b0, rd_busy1, rd_busy2, rd_busy3}, 0);
      @(posedge clk); #1;
      rst_n = 1;

      //            name        w1 a1 d1          w2 a2 d2          cl ca pw pi              inc ra  data            busy pc              conf
      vecs.push_back('{"dual",     1, 0, 32'h2,     1, 1, 32'h2,     0, 0, 0, 0,              0, 1,  32'h2,          0, 32'h0,          0});
      vecs.push_back('{"dual_r0",  0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              0, 0,  32'h2,          0, 32'h0,          0});
      vecs.push_back('{"coll",     1, 2, 32'hAAAA,  1, 2, 32'h5555,  0, 0, 0, 0,              0, 2,  32'h5555,       0, 32'h0,          1});
      vecs.push_back('{"coll_clr", 0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              0, 2,  32'h5555,       0, 32'h0,          0});
      vecs.push_back('{"claim3",   0, 0, 0,         0, 0, 0,         1, 3, 0, 0,              0, 3,  32'h0,          1, 32'h0,          0});
      vecs.push_back('{"wr3",      1, 3, 32'h10,    0, 0, 0,         0, 0, 0, 0,              0, 3,  32'h10,         0, 32'h0,          0});
      vecs.push_back('{"claimwr4", 0, 0, 0,         1, 4, 32'h44,    1, 4, 0, 0,              0, 4,  32'h44,         1, 32'h0,          0});
      vecs.push_back('{"inc1",     0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              1, 15, 32'h4,          0, 32'h4,          0});
      vecs.push_back('{"inc2",     0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              1, 15, 32'h8,          0, 32'h8,          0});
      vecs.push_back('{"inc3",     0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              1, 15, 32'hC,          0, 32'hC,          0});
      vecs.push_back('{"pcwr_inc", 0, 0, 0,         0, 0, 0,         0, 0, 1, 32'h100,        1, 15, 32'h100,        0, 32'h100,        0});
      vecs.push_back('{"pc_top",   0, 0, 0,         0, 0, 0,         0, 0, 1, 32'hFFFFFFFC,   0, 15, 32'hFFFFFFFC,   0, 32'hFFFFFFFC,   0});
      vecs.push_back('{"pc_wrap",  0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              1, 15, 32'h0,          0, 32'h0,          0});
      vecs.push_back('{"pc_ports", 1, 15, 32'h200,  1, 15, 32'h300,  0, 0, 0, 0,              1, 15, 32'h300,        0, 32'h300,        1});
      vecs.push_back('{"claim15",  0, 0, 0,         0, 0, 0,         1, 15, 0, 0,             0, 15, 32'h300,        0, 32'h300,        0});
      vecs.push_back('{"wr_free",  1, 6, 32'h7,     0, 0, 0,         0, 0, 0, 0,              0, 6,  32'h7,          0, 32'h300,        0});
      vecs.push_back('{"wr1_pc",   1, 15, 32'h40,   0, 0, 0,         0, 0, 0, 0,              1, 15, 32'h40,         0, 32'h40,         0});
      vecs.push_back('{"keep4",    0, 0, 0,         0, 0, 0,         0, 0, 0, 0,              0, 4,  32'h44,         1, 32'h40,         0});

      foreach (vecs[k]) begin
         wr_en1 = vecs[k].w1; wr_addr1 = vecs[k].a1; wr_data1 = vecs[k].d1;
         wr_en2 = vecs[k].w2; wr_addr2 = vecs[k].a2; wr_data2 = vecs[k].d2;
         claim_en = vecs[k].cl; claim_addr = vecs[k].ca;
         pc_wr = vecs[k].pw; pc_in = vecs[k].pi; pc_inc = vecs[k].inc;
         @(posedge clk); #1;
         idle_inputs();
         rd_addr1 = vecs[k].ra;
         #1;
         chk({vecs[k].name, "_data"}, rd_data1, vecs[k].exp_data);
         chk({vecs[k].name, "_busy"}, {31'b0, rd_busy1}, {31'b0, vecs[k].exp_busy});
         chk({vecs[k].name, "_pc"}, pc, vecs[k].exp_pc);
         chk({vecs[k].name, "_conf"}, {31'b0, wr_conflict}, {31'b0, vecs[k].exp_conf});
      end

      // Same-cycle read of a register being written
      wr_en2 = 1; wr_addr2 = 5; wr_data2 = 32'h77; rd_addr1 = 5;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_same_cycle", rd_data1, 32'h77);
`else
      chk("bypass_same_cycle", rd_data1, 32'h0);
`endif
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("bypass_after_edge", rd_data1, 32'h77);

      // CPSR load then hold
      cpsr_wr = 1; cpsr_in = 32'hA5;
      @(posedge clk); #1;
      cpsr_wr = 0; cpsr_in = 32'hFF;
      #1;
      chk("cpsr_load", cpsr, 32'hA5);
      @(posedge clk); #1;
      chk("cpsr_hold", cpsr, 32'hA5);

      // Fresh start for the randomized phase
      rst_n = 0; #1;
      chk("rst2_pc", pc, 0);
      chk("rst2_r5", rd_data1, 0);
      rst_n = 1;
      model_reset();

      for (int c = 0; c < 300; c++) begin
         idle_inputs();
         rd_addr1 = 4'($urandom_range(0, 15));
         rd_addr2 = 4'($urandom_range(0, 15));
         rd_addr3 = 4'($urandom_range(0, 15));
         #1;
         chk("rnd_rd1", rd_data1, m_rd(rd_addr1));
         chk("rnd_rd2", rd_data2, m_rd(rd_addr2));
         chk("rnd_rd3", rd_data3, m_rd(rd_addr3));
         chk("rnd_busy", {29'b0, rd_busy1, rd_busy2, rd_busy3},
             {29'b0, m_rb(rd_addr1), m_rb(rd_addr2), m_rb(rd_addr3)});
         chk("rnd_pc", pc, m_pc);
         chk("rnd_cpsr", cpsr, m_cpsr);
         chk("rnd_conf", {31'b0, wr_conflict}, {31'b0, m_conf});
         wr_en1 = 1'($urandom_range(0, 1));
         wr_addr1 = 4'($urandom_range(0, 15));
         wr_data1 = $urandom;
         wr_en2 = 1'($urandom_range(0, 1));
         wr_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr1 : 4'($urandom_range(0, 15));
         wr_data2 = $urandom;
         claim_en = ($urandom_range(0, 2) == 0);
         claim_addr = ($urandom_range(0, 3) == 0) ? wr_addr2 : 4'($urandom_range(0, 15));
         pc_wr = ($urandom_range(0, 7) == 0);
         pc_in = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFF8 : $urandom;
         pc_inc = 1'($urandom_range(0, 1));
         cpsr_wr = ($urandom_range(0, 3) == 0);
         cpsr_in = $urandom;
         @(posedge clk);
         model_step();
         #1;
      end

      // Reset in the middle of a cycle drops a pending claim at once
      idle_inputs();
      claim_en = 1; claim_addr = 3; rd_addr1 = 3;
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("mid_claim", {31'b0, rd_busy1}, 1);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_busy", {31'b0, rd_busy1}, 0);
      chk("mid_rst_data", rd_data1, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_cpsr", cpsr, 0);
      chk("mid_rst_conf", {31'b0, wr_conflict}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
